// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: operand forwarding from
// EX/MEM and MEM/WB into the ALU, load-use bubble insertion, hold and flush.

module id_ex_fwd (
  input  logic        valid_i,
  input  logic [4:0]  idx_i,
  input  logic [31:0] reg_i,
  input  logic        mem_en_i,
  input  logic [4:0]  mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] val_o
);
  logic nz, hit_mem, hit_wb;

  assign nz      = (idx_i != 5'd0);
  assign hit_mem = valid_i & mem_en_i & (mem_addr_i == idx_i) & nz;
  assign hit_wb  = valid_i & wb_en_i  & (wb_addr_i  == idx_i) & nz;

  // Younger producer (EX/MEM) overrides the older one (MEM/WB).
  always_comb begin
    val_o = reg_i;
    if (hit_mem)     val_o = mem_data_i;
    else if (hit_wb) val_o = wb_data_i;
  end
endmodule

module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instruction,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        ex_hold,
  input  logic        flush,
  input  logic        mem_wr_en,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  output logic        ex_valid,
  output logic        id_stall
);
  localparam int NUM_OPS = 2;

  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        valid_q, valid_d;
  logic [4:0]  rs_q, rt_q;
  logic        load_use;

  logic [NUM_OPS-1:0][4:0]  src_idx;
  logic [NUM_OPS-1:0][31:0] opnd_q, opnd_fwd;

  assign rs_q = instr_q[25:21];
  assign rt_q = instr_q[20:16];

  assign src_idx[0] = rs_q;
  assign src_idx[1] = rt_q;
  assign opnd_q[0]  = a_q;
  assign opnd_q[1]  = b_q;

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_fwd
      id_ex_fwd u_fwd (
        .valid_i    (valid_q),
        .idx_i      (src_idx[g]),
        .reg_i      (opnd_q[g]),
        .mem_en_i   (mem_wr_en),
        .mem_addr_i (mem_wr_addr),
        .mem_data_i (mem_wr_data),
        .wb_en_i    (wb_wr_en),
        .wb_addr_i  (wb_wr_addr),
        .wb_data_i  (wb_wr_data),
        .val_o      (opnd_fwd[g])
      );
    end
  endgenerate

  assign alu_instruction = instr_q;
  assign alu_regA        = opnd_fwd[0];
  assign alu_regB        = opnd_fwd[1];
  assign ex_valid        = valid_q;

  // lw in EX whose destination is read by the instruction waiting in ID.
  assign load_use = valid_q & (instr_q[31:26] == 6'h23) & id_valid & (rt_q != 5'd0) &
                    ((rt_q == id_instruction[25:21]) | (rt_q == id_instruction[20:16]));

  assign id_stall = ex_hold | (load_use & ~flush);

  always_comb begin
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = '0;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else if (ex_hold) begin
      // Capture forwarded values so a producer retiring during the hold survives.
      a_d = opnd_fwd[0];
      b_d = opnd_fwd[1];
    end else if (load_use) begin
      instr_d = '0;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
    end else begin
      instr_d = id_valid ? id_instruction : 32'd0;
      a_d     = id_rs_data;
      b_d     = id_rt_data;
      valid_d = id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end
endmodule
